instr_reader_exec: RTL and testbench

Read-side engine for the 32-entry instruction register stack. On a start pulse it walks a contiguous window of register locations by driving read_pointer, and captures each returned instruction word. It executes the opcode on op_a/op_b and streams {address, opcode, result} out over a valid/ready handshake. It sits between the instruction register and any downstream checker or consumer.

---
 rtl/instr_register_pkg.sv | 35 +++
 rtl/instr_alu.sv | 41 ++++
 rtl/instr_reader_exec.sv | 120 ++++++++++++
 tb/tb_instr_reader_exec.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register stack and its read-side engine.
package instr_register_pkg;

    typedef logic signed [31:0] operand_t;
    typedef logic signed [63:0] operand_r;
    typedef logic [4:0]         address_t;

    typedef enum logic [2:0] {
        ZERO  = 3'd0,
        PASSA = 3'd1,
        PASSB = 3'd2,
        ADD   = 3'd3,
        SUB   = 3'd4,
        MULT  = 3'd5,
        DIV   = 3'd6,
        MOD   = 3'd7
    } opcode_t;

    typedef struct packed {
        opcode_t  opc;
        operand_t op_a;
        operand_t op_b;
        operand_r result;
    } instruction_t;

    typedef enum logic [2:0] {
        RD_IDLE    = 3'd0,
        RD_ADDR    = 3'd1,
        RD_CAPTURE = 3'd2,
        RD_EXEC    = 3'd3,
        RD_OUTPUT  = 3'd4,
        RD_FINISH  = 3'd5
    } reader_state_t;

endpackage

// File: rtl/instr_alu.sv
// Combinational opcode executor: operands sign-extended to 64 bits, div/mod by zero flagged.
module instr_alu
    import instr_register_pkg::*;
(
    input  opcode_t  opc,
    input  operand_t op_a,
    input  operand_t op_b,
    output operand_r result,
    output logic     err
);

    operand_r a64;
    operand_r b64;

    assign a64 = operand_r'(op_a);
    assign b64 = operand_r'(op_b);

    // SV signed / truncates toward zero and % takes the dividend's sign.
    always_comb begin
        result = '0;
        err    = 1'b0;
        case (opc)
            ZERO:  result = '0;
            PASSA: result = a64;
            PASSB: result = b64;
            ADD:   result = a64 + b64;
            SUB:   result = a64 - b64;
            MULT:  result = a64 * b64;
            DIV: begin
                if (b64 == '0) err = 1'b1;
                else           result = a64 / b64;
            end
            MOD: begin
                if (b64 == '0) err = 1'b1;
                else           result = a64 % b64;
            end
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/instr_reader_exec.sv
// Walks a window of the instruction register, executes each word and streams the results.
//
//   state      | meaning
//   -----------+---------------------------------------------------
//   RD_IDLE    | waiting for start
//   RD_ADDR    | read_pointer presents ptr to the register
//   RD_CAPTURE | opcode and operands sampled from instruction_word
//   RD_EXEC    | ALU result loaded into the output registers
//   RD_OUTPUT  | out_valid high until out_ready handshake
//   RD_FINISH  | one-cycle done pulse
module instr_reader_exec
    import instr_register_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 6
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [CNT_W-1:0]  count,
    output logic [ADDR_W-1:0] read_pointer,
    input  instruction_t      instruction_word,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output opcode_t           out_opcode,
    output operand_r          out_result,
    output logic              out_err,
    output logic              busy,
    output logic              done
);

    reader_state_t     state_q, state_d;
    logic [ADDR_W-1:0] ptr_q;
    logic [CNT_W-1:0]  rem_q;
    logic [ADDR_W-1:0] rp_q;
    opcode_t           opc_q;
    operand_t          a_q, b_q;
    operand_r          alu_result;
    logic              alu_err;
    logic              handshake;
    logic              unused_result;

    assign unused_result = ^instruction_word.result;

    instr_alu u_alu (
        .opc    (opc_q),
        .op_a   (a_q),
        .op_b   (b_q),
        .result (alu_result),
        .err    (alu_err)
    );

    assign handshake = (state_q == RD_OUTPUT) && out_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            RD_IDLE: begin
                if (start) state_d = (count != '0) ? RD_ADDR : RD_FINISH;
            end
            RD_ADDR:    state_d = RD_CAPTURE;
            RD_CAPTURE: state_d = RD_EXEC;
            RD_EXEC:    state_d = RD_OUTPUT;
            RD_OUTPUT: begin
                if (out_ready) state_d = (rem_q == CNT_W'(1)) ? RD_FINISH : RD_ADDR;
            end
            RD_FINISH:  state_d = RD_IDLE;
            default:    state_d = RD_IDLE;
        endcase
    end

    // rp_q is loaded on entry to RD_ADDR so read_pointer comes straight from a flop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= RD_IDLE;
            ptr_q      <= '0;
            rem_q      <= '0;
            rp_q       <= '0;
            opc_q      <= ZERO;
            a_q        <= '0;
            b_q        <= '0;
            out_addr   <= '0;
            out_opcode <= ZERO;
            out_result <= '0;
            out_err    <= 1'b0;
        end else begin
            state_q <= state_d;
            if ((state_q == RD_IDLE) && start && (count != '0)) begin
                ptr_q <= start_addr;
                rem_q <= count;
                rp_q  <= start_addr;
            end
            if (state_q == RD_CAPTURE) begin
                opc_q <= instruction_word.opc;
                a_q   <= instruction_word.op_a;
                b_q   <= instruction_word.op_b;
            end
            if (state_q == RD_EXEC) begin
                out_addr   <= ptr_q;
                out_opcode <= opc_q;
                out_result <= alu_result;
                out_err    <= alu_err;
            end
            if (handshake) begin
                ptr_q <= ptr_q + 1'b1;
                rem_q <= rem_q - 1'b1;
                if (rem_q != CNT_W'(1)) rp_q <= ptr_q + 1'b1;
            end
        end
    end

    assign read_pointer = rp_q;
    assign out_valid    = (state_q == RD_OUTPUT);
    assign busy         = (state_q == RD_ADDR) || (state_q == RD_CAPTURE) ||
                          (state_q == RD_EXEC) || (state_q == RD_OUTPUT);
    assign done         = (state_q == RD_FINISH);

endmodule

// File: tb/tb_instr_reader_exec.sv
// Directed bench for instr_reader_exec with a behavioural 32-entry instruction register.
module tb_instr_reader_exec;
    import instr_register_pkg::*;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start;
    logic [4:0]   start_addr;
    logic [5:0]   count;
    logic [4:0]   read_pointer;
    instruction_t instruction_word;
    logic         out_valid;
    logic         out_ready;
    logic [4:0]   out_addr;
    opcode_t      out_opcode;
    operand_r     out_result;
    logic         out_err;
    logic         busy;
    logic         done;

    instruction_t mem [32];
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    assign instruction_word = mem[read_pointer];

    instr_reader_exec #(.ADDR_W(5), .CNT_W(6)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .start            (start),
        .start_addr       (start_addr),
        .count            (count),
        .read_pointer     (read_pointer),
        .instruction_word (instruction_word),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_addr         (out_addr),
        .out_opcode       (out_opcode),
        .out_result       (out_result),
        .out_err          (out_err),
        .busy             (busy),
        .done             (done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic instruction_t mk(input opcode_t o, input int a, input int b);
        instruction_t w;
        w.opc    = o;
        w.op_a   = a;
        w.op_b   = b;
        w.result = '0;
        return w;
    endfunction

    // Waits (bounded) for out_valid, checks the beat fields, returns cycles waited.
    task automatic expect_beat(input string tag, input int addr, input opcode_t op,
                               input longint res, input bit err, output int n);
        n = 0;
        while (out_valid !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_addr"}, out_addr, addr);
        chk({tag, "_opcode"}, out_opcode, op);
        chk({tag, "_result"}, out_result, res);
        chk({tag, "_err"}, out_err, err);
    endtask

    task automatic pulse_start(input int addr, input int cnt);
        start      = 1'b1;
        start_addr = 5'(addr);
        count      = 6'(cnt);
        tick();
        start      = 1'b0;
    endtask

    task automatic check_done(input string tag);
        chk({tag, "_done_hi"}, done, 1);
        chk({tag, "_busy_lo"}, busy, 0);
        chk({tag, "_valid_lo"}, out_valid, 0);
        tick();
        chk({tag, "_done_lo"}, done, 0);
    endtask

    task automatic basic_walk(input string tag);
        int n;
        out_ready = 1'b1;
        pulse_start(0, 3);
        chk({tag, "_busy"}, busy, 1);
        expect_beat({tag, "_b0"}, 0, ADD, 8, 0, n);
        chk({tag, "_latency"}, n + 1, 4);
        tick();
        expect_beat({tag, "_b1"}, 1, SUB, -19, 0, n);
        chk({tag, "_spacing"}, n + 1, 4);
        tick();
        expect_beat({tag, "_b2"}, 2, MULT, -42, 0, n);
        tick();
        check_done(tag);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 32; i++) mem[i] = mk(ZERO, 0, 0);
        mem[0]  = mk(ADD, 5, 3);
        mem[1]  = mk(SUB, -15, 4);
        mem[2]  = mk(MULT, 7, -6);
        mem[3]  = mk(SUB, 100, 1);
        mem[5]  = mk(DIV, -15, 4);
        mem[6]  = mk(MOD, -15, 4);
        mem[7]  = mk(DIV, 9, 0);
        mem[10] = mk(PASSB, 1, -2);
        mem[11] = mk(ZERO, 3, 4);
        mem[31] = mk(PASSA, -7, 100);

        // 1: reset holds everything idle even with start high
        reset_n    = 1'b0;
        start      = 1'b1;
        start_addr = 5'd3;
        count      = 6'd2;
        out_ready  = 1'b0;
        #3;
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rp", read_pointer, 0);
        chk("rst_done", done, 0);
        chk("rst_result", out_result, 0);
        chk("rst_opcode", out_opcode, ZERO);
        tick();
        tick();
        chk("rst_hold_busy", busy, 0);
        start   = 1'b0;
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("idle_valid", out_valid, 0);
            chk("idle_busy", busy, 0);
        end

        // 2: basic walk
        basic_walk("walk");

        // 3: division edge cases
        out_ready = 1'b1;
        pulse_start(5, 3);
        expect_beat("div", 5, DIV, -3, 0, n);
        tick();
        expect_beat("mod", 6, MOD, -3, 0, n);
        tick();
        expect_beat("div0", 7, DIV, 0, 1, n);
        tick();
        check_done("divwalk");

        // 4: wrap and backpressure
        out_ready = 1'b0;
        pulse_start(31, 2);
        chk("wrap_rp31", read_pointer, 31);
        expect_beat("wrap_b0", 31, PASSA, -7, 0, n);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_valid", out_valid, 1);
            chk("bp_addr", out_addr, 31);
            chk("bp_result", out_result, -7);
        end
        out_ready = 1'b1;
        tick();
        chk("wrap_rp0", read_pointer, 0);
        expect_beat("wrap_b1", 0, ADD, 8, 0, n);
        tick();
        check_done("wrap");

        // 5: count=0 and ignored start
        pulse_start(4, 0);
        check_done("cnt0");
        chk("cnt0_novalid", out_valid, 0);
        pulse_start(10, 2);
        pulse_start(0, 5);
        expect_beat("ign_b0", 10, PASSB, -2, 0, n);
        tick();
        expect_beat("ign_b1", 11, ZERO, 0, 0, n);
        tick();
        check_done("ign");
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("ign_quiet", out_valid, 0);
        end

        // 6: reset in the middle of beat 2 of 4
        out_ready = 1'b1;
        pulse_start(0, 4);
        expect_beat("mid_b0", 0, ADD, 8, 0, n);
        tick();
        out_ready = 1'b0;
        expect_beat("mid_b1", 1, SUB, -19, 0, n);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_valid", out_valid, 0);
        chk("mid_busy", busy, 0);
        chk("mid_done", done, 0);
        chk("mid_rp", read_pointer, 0);
        chk("mid_addr", out_addr, 0);
        chk("mid_result", out_result, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mid_nodone", done, 0);
        end
        reset_n = 1'b1;
        tick();
        chk("post_rst_done", done, 0);
        basic_walk("rewalk");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
